// File: rtl/video_timing_sequencer_if.sv
// Configuration write channel for video_timing_sequencer.
// The host drives valid/addr/data. The sequencer returns ready and pending.
interface video_timing_sequencer_if #(parameter int CW = 12);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_addr;
  logic [CW-1:0] cfg_data;
  logic          cfg_pending;

  modport master (output cfg_valid, cfg_addr, cfg_data, input cfg_ready, cfg_pending);
  modport slave  (input cfg_valid, cfg_addr, cfg_data, output cfg_ready, cfg_pending);
endinterface

// File: rtl/video_timing_sequencer.sv
// Pixel-rate strobe, h/v counters and sync/active decode in the 5x TMDS clock domain.
// Timing writes land in shadow registers and become live only on the frame wrap.
module video_timing_sequencer #(
  parameter int PHASES     = 5,
  parameter int CW         = 12,
  parameter int H_TOTAL_D  = 800,
  parameter int H_SYNC_D   = 96,
  parameter int H_BP_D     = 144,
  parameter int H_FP_D     = 784,
  parameter int V_TOTAL_D  = 525,
  parameter int V_SYNC_D   = 2,
  parameter int V_BP_D     = 35,
  parameter int V_FP_D     = 515
) (
  input  logic                      clk_x5,
  input  logic                      resetn,
  input  logic                      enable,
  video_timing_sequencer_if.slave   cfg,
  output logic                      pix_strobe,
  output logic [CW-1:0]             hc,
  output logic [CW-1:0]             vc,
  output logic                      active,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      line_start,
  output logic                      frame_start
);
  localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [7:0][CW-1:0] DFLT = {CW'(V_FP_D), CW'(V_BP_D), CW'(V_SYNC_D), CW'(V_TOTAL_D),
                                         CW'(H_FP_D), CW'(H_BP_D), CW'(H_SYNC_D), CW'(H_TOTAL_D)};

  logic [PW-1:0]         r_phase;
  logic                  r_strobe;
  logic [CW-1:0]         r_hc, r_vc;
  logic                  r_pending;
  logic [7:0][CW-1:0]    r_shadow, r_live;
  logic                  w_ph_last, w_h_end, w_v_end, w_commit, w_wr;

  // Totals below 2 would make the wrap compare degenerate.
  function automatic logic [CW-1:0] f_clamp(input int idx, input logic [CW-1:0] v);
    return ((idx == 0 || idx == 4) && v < CW'(2)) ? CW'(2) : v;
  endfunction

  assign w_ph_last = (r_phase == PW'(PHASES-1));
  assign w_h_end   = (r_hc == r_live[0] - CW'(1));
  assign w_v_end   = (r_vc == r_live[4] - CW'(1));
  assign w_commit  = r_strobe && w_h_end && w_v_end && r_pending;
  assign w_wr      = cfg.cfg_valid && cfg.cfg_ready;

  always_ff @(posedge clk_x5 or negedge resetn) begin
    if (!resetn) begin
      r_phase  <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= enable && w_ph_last;
      if (enable) r_phase <= w_ph_last ? '0 : r_phase + PW'(1);
    end
  end

  always_ff @(posedge clk_x5 or negedge resetn) begin
    if (!resetn) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (r_strobe) begin
      if (w_h_end) begin
        r_hc <= '0;
        r_vc <= w_v_end ? '0 : r_vc + CW'(1);
      end else begin
        r_hc <= r_hc + CW'(1);
      end
    end
  end

  // Write and commit cannot coincide: ready is low in the commit cycle.
  always_ff @(posedge clk_x5 or negedge resetn) begin
    if (!resetn) begin
      r_pending <= 1'b0;
      r_shadow  <= DFLT;
      r_live    <= DFLT;
    end else begin
      if (w_commit) begin
        r_pending <= 1'b0;
        for (int i = 0; i < 8; i++) r_live[i] <= f_clamp(i, r_shadow[i]);
      end
      if (w_wr) begin
        r_pending               <= 1'b1;
        r_shadow[cfg.cfg_addr]  <= cfg.cfg_data;
      end
    end
  end

  assign cfg.cfg_ready   = !w_commit;
  assign cfg.cfg_pending = r_pending;
  assign pix_strobe      = r_strobe;
  assign hc              = r_hc;
  assign vc              = r_vc;
  assign active          = (r_hc >= r_live[2]) && (r_hc < r_live[3]) &&
                           (r_vc >= r_live[6]) && (r_vc < r_live[7]);
  assign hsync           = r_hc < r_live[1];
  assign vsync           = r_vc < r_live[5];
  assign line_start      = r_strobe && (r_hc == '0);
  assign frame_start     = r_strobe && (r_hc == '0) && (r_vc == '0);
endmodule

// File: tb/tb_video_timing_sequencer.sv
// Scoreboard bench: a reference model predicts the state after each edge.
// The bench pushes that prediction and pops it once the DUT has clocked.
module tb_video_timing_sequencer;
  localparam int CW = 12;
  localparam int DEF[8] = '{20, 3, 5, 17, 8, 1, 2, 7};

  logic          clk_x5 = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          pix_strobe, active, hsync, vsync, line_start, frame_start;
  logic [CW-1:0] hc, vc;

  video_timing_sequencer_if #(.CW(CW)) cfg_if();

  video_timing_sequencer #(
    .PHASES(5), .CW(CW),
    .H_TOTAL_D(20), .H_SYNC_D(3), .H_BP_D(5), .H_FP_D(17),
    .V_TOTAL_D(8),  .V_SYNC_D(1), .V_BP_D(2), .V_FP_D(7)
  ) u_dut (
    .clk_x5(clk_x5), .resetn(resetn), .enable(enable), .cfg(cfg_if.slave),
    .pix_strobe(pix_strobe), .hc(hc), .vc(vc), .active(active), .hsync(hsync),
    .vsync(vsync), .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk_x5 = ~clk_x5;

  int          n_chk = 0, n_fail = 0;
  int          n_stb, n_act;
  logic [63:0] q_exp[$];
  int          m_ph, m_hc, m_vc, m_sh[8], m_lv[8];
  bit          m_stb, m_pend;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_vec();
    logic a, hs, vs, ls, fs;
    a  = m_hc >= m_lv[2] && m_hc < m_lv[3] && m_vc >= m_lv[6] && m_vc < m_lv[7];
    hs = m_hc < m_lv[1];
    vs = m_vc < m_lv[5];
    ls = m_stb && m_hc == 0;
    fs = ls && m_vc == 0;
    return 64'({m_pend, m_stb, 12'(m_hc), 12'(m_vc), a, hs, vs, ls, fs});
  endfunction

  function automatic logic [63:0] dut_vec();
    return 64'({cfg_if.cfg_pending, pix_strobe, hc, vc, active, hsync, vsync, line_start, frame_start});
  endfunction

  task automatic model_reset();
    m_ph = 0; m_hc = 0; m_vc = 0; m_stb = 0; m_pend = 0;
    for (int i = 0; i < 8; i++) begin m_sh[i] = DEF[i]; m_lv[i] = DEF[i]; end
  endtask

  // Called at a negedge: drive inputs, predict, clock, compare, return at next negedge.
  task automatic step(input bit en, input bit v, input int a, input int d);
    bit commit;
    int nhc, nvc;
    enable = en;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_addr  = a[2:0];
    cfg_if.cfg_data  = d[CW-1:0];
    commit = m_stb && m_hc == m_lv[0] - 1 && m_vc == m_lv[4] - 1 && m_pend;
    #1 chk("cfg_ready", 64'(cfg_if.cfg_ready), 64'(!commit));
    nhc = m_hc; nvc = m_vc;
    if (m_stb) begin
      if (m_hc == m_lv[0] - 1) begin
        nhc = 0;
        nvc = (m_vc == m_lv[4] - 1) ? 0 : m_vc + 1;
      end else nhc = m_hc + 1;
    end
    if (commit) begin
      for (int i = 0; i < 8; i++) m_lv[i] = m_sh[i];
      if (m_lv[0] < 2) m_lv[0] = 2;
      if (m_lv[4] < 2) m_lv[4] = 2;
      m_pend = 0;
    end
    if (v && !commit) begin m_sh[a] = d; m_pend = 1; end
    m_stb = en && m_ph == 4;
    if (en) m_ph = (m_ph + 1) % 5;
    m_hc = nhc; m_vc = nvc;
    q_exp.push_back(exp_vec());
    @(posedge clk_x5); #1;
    chk("state", dut_vec(), q_exp.pop_front());
    if (pix_strobe) begin n_stb++; if (active) n_act++; end
    @(negedge clk_x5);
  endtask

  // Called at a negedge; outputs must drop to reset values without a clock edge.
  task automatic do_reset();
    resetn = 1'b0; enable = 1'b0; cfg_if.cfg_valid = 1'b0;
    #1;
    model_reset();
    chk("reset_state", dut_vec(), exp_vec());
    chk("reset_ready", 64'(cfg_if.cfg_ready), 64'(1));
    @(posedge clk_x5);
    @(negedge clk_x5);
    resetn = 1'b1;
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_addr = '0; cfg_if.cfg_data = '0;
    @(negedge clk_x5);
    do_reset();

    // One default frame: 20x8 pixels, 12x5 visible.
    n_stb = 0; n_act = 0;
    repeat (800) step(1, 0, 0, 0);
    chk("strobes_per_frame", 64'(n_stb), 64'(160));
    chk("active_per_frame", 64'(n_act), 64'(60));

    // Mid-frame writes, last write to h_total wins; commit at frame end.
    repeat (123) step(1, 0, 0, 0);
    step(1, 1, 0, 7);
    step(1, 1, 0, 10);
    step(1, 1, 4, 4);
    chk("pending_set", 64'(cfg_if.cfg_pending), 64'(1));
    repeat (1000) step(1, 0, 0, 0);
    chk("pending_clear", 64'(cfg_if.cfg_pending), 64'(0));

    // Valid held high across commit cycles.
    step(1, 1, 5, 2);
    repeat (250) step(1, 1, 1, 4);

    // Totals below 2 clamp to 2, then restore a mid-size raster.
    step(1, 1, 0, 1);
    step(1, 1, 4, 0);
    repeat (300) step(1, 0, 0, 0);
    step(1, 1, 0, 12);
    step(1, 1, 4, 5);
    repeat (400) step(1, 0, 0, 0);

    // Enable dropped for 7 cycles mid-line.
    repeat (3) step(1, 0, 0, 0);
    repeat (7) step(0, 0, 0, 0);
    repeat (40) step(1, 0, 0, 0);

    // Reset mid-frame with a pending write: defaults return.
    step(1, 1, 2, 9);
    repeat (20) step(1, 0, 0, 0);
    do_reset();
    n_stb = 0; n_act = 0;
    repeat (800) step(1, 0, 0, 0);
    chk("active_after_reset", 64'(n_act), 64'(60));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
